delay_sample_feeder: RTL
========================

Name: delay_sample_feeder

Overview:
Per-channel sample transmitter that drives the receive side of one delay/sum channel in the 32-channel datapath. It buffers incoming samples in a small FIFO and holds off a programmed number of clocks after a start pulse. It then issues samples one at a time on x_o_porty/srdyi_o and closes each handshake on the channel's delay strobe. It also generates that channel's sum_en/sum_rst controls.

Parameters:
DATA_W, 32, sample width
DEPTH, 16, FIFO depth in words (power of 2, >=2)
DLY_W, 8, width of the start-delay count
TO_CYC, 15, cycles to wait for the ack strobe before declaring a timeout (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
GlobalReset  in  1  synchronous, active-high reset
din  in  DATA_W  sample in
din_valid  in  1  push request; accepted when din_ready=1
din_ready  out  1  FIFO not full
delay_cfg  in  DLY_W  start delay in clocks
cfg_load  in  1  latch delay_cfg (honoured in IDLE only)
start  in  1  one-cycle frame start
stop  in  1  one-cycle stop request
x_o_porty  out  DATA_W  sample to channel
srdyi_o  out  1  one-cycle sample-ready strobe
delay_i  in  1  ack strobe from channel (delay_o of the channel)
sum_en_o  out  1  channel sum enable
sum_rst_o  out  1  channel sum reset pulse
fifo_count  out  $clog2(DEPTH)+1  words held
busy  out  1  state != IDLE
to_err  out  1  sticky ack-timeout flag

Behaviour:
- Reset (GlobalReset=1 at an edge, any state): FSM=IDLE; FIFO emptied (count 0). Outputs x_o_porty, srdyi_o, sum_en_o, sum_rst_o, busy and to_err are 0. din_ready=1. The latched delay register is 0. Reset mid-handshake abandons the sample with no ack wait.
- FIFO: push when din_valid && din_ready. din_ready = !full, so pushes are refused when full even in a pop cycle. Pop occurs only on entry to ISSUE. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged. Pointers wrap modulo DEPTH.
- States: IDLE, DELAY, ISSUE, WAIT_ACK, WAIT_REL, STARVE.
- IDLE:
  - cfg_load latches delay_cfg.
  - start: sum_rst_o=1 for exactly the next cycle, sum_en_o=1. Next state is DELAY with counter = latched delay, or, if the latched delay = 0, ISSUE (when count>0) or STARVE (when empty).
  - stop is ignored in IDLE.
- DELAY: counter decrements each clock. At counter==1 the next state is ISSUE if count>0, else STARVE. Total hold from start to first srdyi_o = delay+1 clocks (delay>=1). The delay=0 case gives 1 clock.
- ISSUE (1 cycle): srdyi_o=1 and x_o_porty = popped word, registered so both change on the same edge. x_o_porty holds its value until the next ISSUE. Next state is WAIT_ACK and the timeout counter clears.
- WAIT_ACK:
  - delay_i=1 goes to WAIT_REL.
  - If TO_CYC cycles pass without delay_i, set to_err and treat the sample as lost (no retry). Then proceed as on WAIT_REL exit.
- WAIT_REL: wait for delay_i=0. On that cycle:
  - pending stop: go to IDLE with sum_en_o=0;
  - count>0: go to ISSUE;
  - otherwise: go to STARVE.
  - Nominal channel: srdyi at t, ack at t+1, release at t+2, next srdyi at t+3. Max rate is 1 sample per 3 clocks.
- STARVE: sum_en_o stays 1. When count>0, go to ISSUE next cycle. stop goes to IDLE immediately.
- stop handling:
  - In DELAY: abort to IDLE next cycle.
  - In ISSUE/WAIT_ACK/WAIT_REL: latched as pending and honoured at handshake completion.
  - In all cases sum_en_o falls on IDLE entry.
  - start and stop in the same cycle in IDLE: start wins. In any non-IDLE state, start is ignored.
- to_err clears only on GlobalReset. srdyi_o is never high on two consecutive cycles.

Test Plan:
- Reset mid-WAIT_ACK with 5 words queued -> next cycle: srdyi_o=0, sum_en_o=0, fifo_count=0, busy=0, x_o_porty=0.
- Delay/order: load delay_cfg=4, push 0x11,0x22,0x33, start at cycle 0, model channel (ack at t+1, release at t+2) -> sum_rst_o high at cycle 1. srdyi_o at cycles 5, 8 and 11 with x_o_porty 0x11, 0x22 and 0x33. Then STARVE with sum_en_o=1.
- Full FIFO: push 17 words with channel stalled -> din_ready=0 after the 16th, 17th refused, fifo_count=16. Release -> 16 samples out in order, wrap verified on a second fill.
- Timeout: channel never acks, one word queued -> srdyi_o once, to_err=1 after 15 cycles. The next word issues afterwards and to_err stays 1.
- Stop mid-handshake: stop during WAIT_ACK with words queued -> current ack completes. Then IDLE, sum_en_o=0, remaining words stay in FIFO (count unchanged).
- Delay 0 with empty FIFO: start -> STARVE. Push 0xABCD -> srdyi_o two cycles after the push edge with x_o_porty=0xABCD.

Source files
------------

// File: rtl/delay_sample_feeder_if.sv
// Bundle of the sample-in, control and channel-side signals of one
// delay_sample_feeder. The master drives samples, configuration and the
// channel ack; the slave is the feeder itself.
interface delay_sample_feeder_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int DLY_W  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [DLY_W-1:0]  delay_cfg;
  logic              cfg_load;
  logic              start;
  logic              stop;
  logic [DATA_W-1:0] x_o_porty;
  logic              srdyi_o;
  logic              delay_i;
  logic              sum_en_o;
  logic              sum_rst_o;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;
  logic              to_err;
  logic [2:0]        state_dbg;

  modport master (
    output din, din_valid, delay_cfg, cfg_load, start, stop, delay_i,
    input  din_ready, x_o_porty, srdyi_o, sum_en_o, sum_rst_o,
           fifo_count, busy, to_err, state_dbg
  );

  modport slave (
    input  din, din_valid, delay_cfg, cfg_load, start, stop, delay_i,
    output din_ready, x_o_porty, srdyi_o, sum_en_o, sum_rst_o,
           fifo_count, busy, to_err, state_dbg
  );
endinterface

// File: rtl/delay_sample_feeder.sv
// Per-channel sample transmitter: buffers samples in a small FIFO, waits a
// programmed number of clocks after start, then hands samples one at a time
// to a delay/sum channel and generates that channel's sum_en/sum_rst.
//
// Handshakes:
//   din side  - a word transfers on every rising edge where din_valid and
//               din_ready are both 1; din_ready is simply "FIFO not full",
//               so a pop in the same cycle never frees room early.
//   chan side - srdyi_o is a one-cycle strobe with x_o_porty valid in that
//               cycle; the channel acks by raising delay_i and the transfer
//               closes once delay_i falls again (or the ack wait times out).
module delay_sample_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int DLY_W  = 8,
  parameter int TO_CYC = 15
) (
  input  logic                 clk,
  input  logic                 GlobalReset,
  delay_sample_feeder_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int TO_W  = $clog2(TO_CYC);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_REL = 3'd4,
    S_STARVE   = 3'd5
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DLY_W-1:0]  delay_q, cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              stop_pend_q;
  logic [DATA_W-1:0] x_q;
  logic              srdy_q, sum_en_q, sum_rst_q, to_err_q;

  logic   full, have, push, pop, stop_now, to_hit;
  state_t hs_next;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign have     = (count_q != '0);
  assign push     = bus.din_valid && !full;
  assign stop_now = stop_pend_q || bus.stop;
  assign to_hit   = (state_q == S_WAIT_ACK) && !bus.delay_i &&
                    (to_cnt_q == TO_W'(TO_CYC - 1));
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  // Pop decision (pop == entering ISSUE) and the exit target of a handshake
  always_comb begin
    pop     = 1'b0;
    hs_next = S_STARVE;
    if (stop_now)  hs_next = S_IDLE;
    else if (have) hs_next = S_ISSUE;
    case (state_q)
      S_IDLE:     pop = bus.start && (delay_q == '0) && have;
      S_DELAY:    pop = !bus.stop && (cnt_q == DLY_W'(1)) && have;
      S_WAIT_ACK: pop = to_hit && !stop_now && have;
      S_WAIT_REL: pop = !bus.delay_i && !stop_now && have;
      S_STARVE:   pop = !bus.stop && have;
      default:    pop = 1'b0;
    endcase
  end

  // FIFO storage write (no reset needed on the data array)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.din;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Control FSM with registered channel-side outputs
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q     <= S_IDLE;
      delay_q     <= '0;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      stop_pend_q <= 1'b0;
      x_q         <= '0;
      srdy_q      <= 1'b0;
      sum_en_q    <= 1'b0;
      sum_rst_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      srdy_q    <= 1'b0;
      sum_rst_q <= 1'b0;
      if (pop) begin
        x_q    <= mem[rd_ptr_q];
        srdy_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_load) delay_q <= bus.delay_cfg;
          if (bus.start) begin
            sum_rst_q   <= 1'b1;
            sum_en_q    <= 1'b1;
            stop_pend_q <= 1'b0;
            if (delay_q != '0) begin
              state_q <= S_DELAY;
              cnt_q   <= delay_q;
            end else begin
              state_q <= have ? S_ISSUE : S_STARVE;
            end
          end
        end
        S_DELAY: begin
          if (bus.stop) begin
            state_q  <= S_IDLE;
            sum_en_q <= 1'b0;
          end else if (cnt_q == DLY_W'(1)) begin
            state_q <= have ? S_ISSUE : S_STARVE;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        S_ISSUE: begin
          if (bus.stop) stop_pend_q <= 1'b1;
          state_q  <= S_WAIT_ACK;
          to_cnt_q <= '0;
        end
        S_WAIT_ACK: begin
          if (bus.stop) stop_pend_q <= 1'b1;
          if (bus.delay_i) begin
            state_q <= S_WAIT_REL;
          end else if (to_hit) begin
            // Sample is written off as lost; carry on as if released
            to_err_q <= 1'b1;
            state_q  <= hs_next;
            if (hs_next == S_IDLE) begin
              sum_en_q    <= 1'b0;
              stop_pend_q <= 1'b0;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_WAIT_REL: begin
          if (bus.stop) stop_pend_q <= 1'b1;
          if (!bus.delay_i) begin
            state_q <= hs_next;
            if (hs_next == S_IDLE) begin
              sum_en_q    <= 1'b0;
              stop_pend_q <= 1'b0;
            end
          end
        end
        S_STARVE: begin
          if (bus.stop) begin
            state_q  <= S_IDLE;
            sum_en_q <= 1'b0;
          end else if (have) begin
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.din_ready  = !full;
  assign bus.x_o_porty  = x_q;
  assign bus.srdyi_o    = srdy_q;
  assign bus.sum_en_o   = sum_en_q;
  assign bus.sum_rst_o  = sum_rst_q;
  assign bus.fifo_count = count_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.to_err     = to_err_q;
  assign bus.state_dbg  = state_q;
endmodule
